// File: rtl/morse_pkg.sv
// Shared constants for the Morse decoder display path: glyph table,
// blank/unknown markers, full-policy selectors and the buffer operation type.
package morse_pkg;

  localparam logic [7:0] BLANK_GLYPH   = 8'h00;
  localparam logic [7:0] UNKNOWN_GLYPH = 8'h02;

  localparam int FULL_MODE_SCROLL = 0;
  localparam int FULL_MODE_LOCK   = 1;

  // Seven-segment glyphs {a,b,c,d,e,f,g,dp}, indexed by hex digit (entry 0 is rightmost)
  localparam logic [15:0][7:0] GLYPH_TABLE = {
    8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

  // Operation selected for the buffer in a given cycle, already prioritised
  typedef enum logic [1:0] {
    OP_NONE,
    OP_CLEAR,
    OP_BACKSPACE,
    OP_PUSH
  } buf_op_t;

  function automatic logic [7:0] glyph_lookup(input logic [3:0] idx);
    return GLYPH_TABLE[idx];
  endfunction

endpackage

// File: rtl/morse_seg_encode.sv
// Combinational character-code to seven-segment glyph lookup.
// Codes beyond the hex range show the decimal-point-only marker.
module morse_seg_encode #(
  parameter int CODE_W = 4,
  parameter int SEG_W  = 8
) (
  input  logic [CODE_W-1:0] code_in,
  output logic [SEG_W-1:0]  glyph
);
  import morse_pkg::*;

  logic [3:0] idx;
  logic       unknown;

  generate
    if (CODE_W > 4) begin : g_wide
      assign idx     = code_in[3:0];
      assign unknown = |code_in[CODE_W-1:4];
    end else begin : g_narrow
      assign idx     = 4'(code_in);
      assign unknown = 1'b0;
    end
  endgenerate

  // Table lookup, overridden by the unknown marker for out-of-range codes
  always_comb begin
    glyph = SEG_W'(glyph_lookup(idx));
    if (unknown) glyph = SEG_W'(UNKNOWN_GLYPH);
  end

endmodule

// File: rtl/morse_char_buffer.sv
// Display character buffer: edge-detected push/backspace into a DEPTH-slot
// shift buffer of glyphs, with clear, fill count, full policy and sticky
// overflow. Slot 0 holds the newest character.
module morse_char_buffer #(
  parameter int DEPTH     = 8,
  parameter int CODE_W    = 4,
  parameter int SEG_W     = 8,
  parameter int FULL_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       push,
  input  logic                       backspace,
  input  logic                       clear,
  input  logic [CODE_W-1:0]          code_in,
  output logic [DEPTH*SEG_W-1:0]     seg_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);
  import morse_pkg::*;

  localparam int CNT_W = $clog2(DEPTH+1);

  logic             push_q;
  logic             bs_q;
  logic             push_ev;
  logic             bs_ev;
  logic [SEG_W-1:0] glyph;
  buf_op_t          op;

  logic [SEG_W-1:0] slot_reg  [DEPTH];
  logic [SEG_W-1:0] slot_next [DEPTH];
  logic [SEG_W-1:0] shift_up  [DEPTH];
  logic [SEG_W-1:0] shift_dn  [DEPTH];
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             ovf_reg;
  logic             ovf_next;

  morse_seg_encode #(
    .CODE_W (CODE_W),
    .SEG_W  (SEG_W)
  ) u_encode (
    .code_in (code_in),
    .glyph   (glyph)
  );

  assign push_ev = push & ~push_q;
  assign bs_ev   = backspace & ~bs_q;

  // Shift-up (push) and shift-down (backspace) candidates per slot, plus the flat output bus
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      if (gi == 0) begin : g_first
        assign shift_up[gi] = glyph;
      end else begin : g_mid_up
        assign shift_up[gi] = slot_reg[gi-1];
      end
      if (gi == DEPTH-1) begin : g_last
        assign shift_dn[gi] = SEG_W'(BLANK_GLYPH);
      end else begin : g_mid_dn
        assign shift_dn[gi] = slot_reg[gi+1];
      end
      assign seg_out[gi*SEG_W +: SEG_W] = slot_reg[gi];
    end
  endgenerate

  assign count    = count_reg;
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign overflow = ovf_reg;

  // Prioritise clear over backspace over push; en gates only the button events
  always_comb begin
    op = OP_NONE;
    if (clear)               op = OP_CLEAR;
    else if (en && bs_ev)    op = OP_BACKSPACE;
    else if (en && push_ev)  op = OP_PUSH;
  end

  // Next-state for slots, count and overflow
  always_comb begin
    slot_next  = slot_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;
    case (op)
      OP_CLEAR: begin
        for (int i = 0; i < DEPTH; i++) slot_next[i] = SEG_W'(BLANK_GLYPH);
        count_next = '0;
        ovf_next   = 1'b0;
      end
      OP_BACKSPACE: begin
        if (!empty) begin
          slot_next  = shift_dn;
          count_next = count_reg - 1'b1;
        end
      end
      OP_PUSH: begin
        if (!full) begin
          slot_next  = shift_up;
          count_next = count_reg + 1'b1;
        end else begin
          ovf_next = 1'b1;
          // Scroll mode drops the oldest character; lock mode keeps the buffer intact
          if (FULL_MODE != FULL_MODE_LOCK) slot_next = shift_up;
        end
      end
      default: ;
    endcase
  end

  // State registers; edge-detect flops run regardless of en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_q    <= 1'b0;
      bs_q      <= 1'b0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) slot_reg[i] <= SEG_W'(BLANK_GLYPH);
    end else begin
      push_q    <= push;
      bs_q      <= backspace;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      slot_reg  <= slot_next;
    end
  end

endmodule

// File: tb/tb_morse_char_buffer.sv
// Directed bench: a scroll-mode buffer (4-bit codes) and a lock-mode buffer
// (5-bit codes) driven with the same buttons, checked against hand values.
module tb_morse_char_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        push;
  logic        backspace;
  logic        clear;
  logic [3:0]  code_in;
  logic        code_hi;
  logic [4:0]  code5;

  logic [63:0] seg_s, seg_l;
  logic [3:0]  count_s, count_l;
  logic        full_s, full_l, empty_s, empty_l, ovf_s, ovf_l;

  int total = 0;
  int bad   = 0;

  assign code5 = {code_hi, code_in};

  always #5 clk = ~clk;

  morse_char_buffer #(.DEPTH(8), .CODE_W(4), .SEG_W(8), .FULL_MODE(0)) dut_s (
    .clk(clk), .rst(rst), .en(en), .push(push), .backspace(backspace),
    .clear(clear), .code_in(code_in), .seg_out(seg_s), .count(count_s),
    .full(full_s), .empty(empty_s), .overflow(ovf_s)
  );

  morse_char_buffer #(.DEPTH(8), .CODE_W(5), .SEG_W(8), .FULL_MODE(1)) dut_l (
    .clk(clk), .rst(rst), .en(en), .push(push), .backspace(backspace),
    .clear(clear), .code_in(code5), .seg_out(seg_l), .count(count_l),
    .full(full_l), .empty(empty_l), .overflow(ovf_l)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic do_push(input logic [3:0] c);
    @(negedge clk);
    code_in = c;
    push    = 1'b1;
    @(negedge clk);
    push    = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_bs();
    @(negedge clk);
    backspace = 1'b1;
    @(negedge clk);
    backspace = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; push = 1'b0; backspace = 1'b0; clear = 1'b0;
    code_in = 4'd0; code_hi = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_seg",   seg_s, 64'h0);
    chk("rst_count", 64'(count_s), 64'd0);
    chk("rst_empty", 64'(empty_s), 64'd1);
    chk("rst_full",  64'(full_s), 64'd0);
    chk("rst_ovf",   64'(ovf_s), 64'd0);
    rst = 1'b0;
    en  = 1'b1;

    // Three separate pushes: newest in slot 0
    do_push(4'd1); do_push(4'd2); do_push(4'd3);
    chk("push3_seg",   seg_s, 64'h0000_0000_0060_DAF2);
    chk("push3_count", 64'(count_s), 64'd3);
    chk("push3_empty", 64'(empty_s), 64'd0);
    chk("push3_seg_l", seg_l, 64'h0000_0000_0060_DAF2);

    // Backspace removes the newest
    do_bs();
    chk("bs1_seg",   seg_s, 64'h0000_0000_0000_60DA);
    chk("bs1_count", 64'(count_s), 64'd2);

    // Back to three, then push and backspace rise together: only backspace acts
    do_push(4'd4);
    chk("push4_seg", seg_s, 64'h0000_0000_0060_DA66);
    @(negedge clk);
    code_in = 4'd5; push = 1'b1; backspace = 1'b1;
    @(negedge clk);
    push = 1'b0; backspace = 1'b0;
    @(negedge clk);
    chk("both_count", 64'(count_s), 64'd2);
    chk("both_seg",   seg_s, 64'h0000_0000_0000_60DA);

    // Drain to empty and one extra backspace: no underflow
    do_bs(); do_bs(); do_bs();
    chk("drain_count", 64'(count_s), 64'd0);
    chk("drain_empty", 64'(empty_s), 64'd1);
    chk("drain_seg",   seg_s, 64'h0);
    chk("drain_ovf",   64'(ovf_s), 64'd0);

    // Nine pushes of 0 then one of 1
    for (int i = 0; i < 9; i++) do_push(4'd0);
    do_push(4'd1);
    chk("scr_count", 64'(count_s), 64'd8);
    chk("scr_full",  64'(full_s), 64'd1);
    chk("scr_ovf",   64'(ovf_s), 64'd1);
    chk("scr_seg",   seg_s, 64'hFCFC_FCFC_FCFC_FC60);
    chk("lck_seg",   seg_l, 64'hFCFC_FCFC_FCFC_FCFC);
    chk("lck_ovf",   64'(ovf_l), 64'd1);
    chk("lck_count", 64'(count_l), 64'd8);

    // One more push of 2 while full
    do_push(4'd2);
    chk("lck2_seg", seg_l, 64'hFCFC_FCFC_FCFC_FCFC);
    chk("scr2_seg", seg_s, 64'hFCFC_FCFC_FCFC_60DA);

    // Clear wipes buffer, count and overflow
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clr_seg_l",   seg_l, 64'h0);
    chk("clr_count_l", 64'(count_l), 64'd0);
    chk("clr_ovf_l",   64'(ovf_l), 64'd0);
    chk("clr_ovf_s",   64'(ovf_s), 64'd0);
    chk("clr_empty_s", 64'(empty_s), 64'd1);

    // Code 7 on the scroll buffer, code 23 (unknown) on the 5-bit lock buffer
    code_hi = 1'b1;
    do_push(4'd7);
    code_hi = 1'b0;
    chk("c7_seg_s",  seg_s, 64'h0000_0000_0000_00E0);
    chk("c23_seg_l", seg_l, 64'h0000_0000_0000_0002);

    // Push while disabled is ignored
    en = 1'b0;
    do_push(4'd8);
    chk("dis_count", 64'(count_s), 64'd1);
    chk("dis_seg",   seg_s, 64'h0000_0000_0000_00E0);

    // Clear acts even while disabled
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("dis_clr_count", 64'(count_s), 64'd0);

    // Push held high across en rising produces no event
    @(negedge clk); code_in = 4'd9; push = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);
    chk("hold_count", 64'(count_s), 64'd0);
    push = 1'b0;

    // Asynchronous reset mid-sequence takes effect without a clock edge
    do_push(4'd3); do_push(4'd6);
    chk("pre_rst_count", 64'(count_s), 64'd2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 64'(count_s), 64'd0);
    chk("arst_seg",   seg_s, 64'h0);
    chk("arst_empty", 64'(empty_s), 64'd1);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morse_char_buffer.md
Name: morse_char_buffer

Overview:
Parametrised display character buffer for the Morse decoder front panel. It accepts decoded character codes, converts each one to a seven-segment glyph, and holds them in a DEPTH-slot shift buffer. The buffer drives the multiplexed display scanner through a flat segment bus. It adds edge-detected push/backspace, clear, fill count, a full policy and a sticky overflow flag.

Parameters:
DEPTH, 8, number of display slots (2..16).
CODE_W, 4, width of incoming character code.
SEG_W, 8, glyph width per slot, {a,b,c,d,e,f,g,dp} with a as MSB, active-high.
FULL_MODE, 0, 0 = SCROLL (oldest character dropped when full), 1 = LOCK (push ignored when full).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  block enable; when low, buffer events are ignored
push  in  1  level from debounced commit button; a rising edge commits code_in
backspace  in  1  level from debounced backspace button; a rising edge deletes the newest character
clear  in  1  synchronous clear, level-sensitive, highest priority
code_in  in  CODE_W  character code to commit
seg_out  out  DEPTH*SEG_W  slot 0 = bits [SEG_W-1:0] = newest character
count  out  $clog2(DEPTH+1)  number of occupied slots
full  out  1  count == DEPTH
empty  out  1  count == 0
overflow  out  1  sticky; set on a push while full

Behaviour:
- Reset (async): all slots = 8'h00 (blank), count = 0, overflow = 0, edge registers = 0. Outputs are therefore full = 0, empty = 1.
- Edge detection:
  - push_q and bs_q register push and backspace every cycle, independent of en.
  - push_ev = push & ~push_q; bs_ev = backspace & ~bs_q.
  - A button held while en rises therefore produces no event.
- Priority per cycle when en = 1: clear > bs_ev > push_ev. Simultaneous bs_ev and push_ev: only the backspace executes and the push is lost.
- clear: all slots blank, count = 0, overflow = 0. Takes effect even if en = 0.
- push_ev:
  - Glyph = encode(code_in), sampled in the event cycle.
  - slot[i] <= slot[i-1] for i = DEPTH-1..1; slot[0] <= glyph.
  - Not full: count + 1.
  - Full, SCROLL: shift anyway, slot DEPTH-1 is lost, count stays DEPTH, overflow <= 1.
  - Full, LOCK: no change to slots or count, overflow <= 1.
- bs_ev:
  - Not empty: slot[i] <= slot[i+1], slot[DEPTH-1] <= blank, count - 1.
  - Empty: no-op. overflow is not affected.
- Latency: seg_out and count update on the clock edge after the rising edge of push or backspace is sampled, i.e. one cycle after the event cycle.
- en = 0: slots, count and overflow hold; only the edge registers update.
- Encoding:
  - Codes 0..15 map to hex glyphs: 0 = 8'hFC, 1 = 8'h60, 2 = 8'hDA, 3 = 8'hF2, 4 = 8'h66, 5 = 8'hB6, 6 = 8'hBE, 7 = 8'hE0, 8 = 8'hFE, 9 = 8'hF6, A = 8'hEE, b = 8'h3E, C = 8'h9C, d = 8'h7A, E = 8'h9E, F = 8'h8E.
  - When CODE_W > 4, codes >= 16 map to 8'h02 (dp only, the "unknown symbol" marker).
- count never exceeds DEPTH and never underflows. full and empty are combinational from count.

Decomposition:
- Package morse_pkg holds: BLANK_GLYPH (8'h00), UNKNOWN_GLYPH (8'h02), the 16-entry glyph table, and FULL_MODE_SCROLL / FULL_MODE_LOCK constants.
- Sub-module morse_seg_encode: purely combinational code-to-glyph lookup, parametrised on CODE_W. It is reused by the status display.
- The buffer, counter, edge detection and overflow logic live in morse_char_buffer.

Test Plan:
1. Reset, then push codes 1,2,3 as separate pulses (en = 1) -> low 24 bits of seg_out = 8'h60_DA_F2, with slot0 = 8'hF2; count = 3; empty = 0.
2. DEPTH = 8, SCROLL: push 9 times with code 0, then once with code 1 -> count = 8, full = 1, overflow = 1, slot0 = 8'h60, slots1..7 = 8'hFC.
3. FULL_MODE = 1, buffer full of 8'hFC: push code 2 -> seg_out unchanged, overflow = 1. Then clear -> all slots 8'h00, count = 0, overflow = 0.
4. Contents 1,2 (slot0 = 8'hDA): backspace -> slot0 = 8'h60, count = 1. Two further backspaces -> empty = 1, count = 0, no underflow.
5. Push and backspace rising in the same cycle with count = 3 -> count = 2, no new glyph.
6. Hold push high, toggle en 0->1 -> no event. Push a code while en = 0 -> no change. Assert rst mid-sequence -> all outputs at reset values immediately, without waiting for a clock edge.
